// File: rtl/sb_pkg.sv
// Shared types and constants for the store buffer and its forwarding merge.
// The entry layout keeps the word address only; byte offsets live in the enables.
package sb_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;
  localparam int SB_BEW   = SB_DW / 8;
  localparam int SB_PCW   = 32;

  typedef struct packed {
    logic [SB_AW-1:2]  addr;
    logic [SB_DW-1:0]  data;
    logic [SB_BEW-1:0] be;
    logic [SB_PCW-1:0] pc;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_merge.sv
// Combinational byte-lane merge of pending stores for load forwarding.
// Entries are visited oldest to youngest so the youngest matching byte wins.
module sb_fwd_merge
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int PW    = $clog2(DEPTH)
) (
  input  sb_entry_t          entries [DEPTH],
  input  logic [DEPTH-1:0]   valid,
  input  logic [PW-1:0]      rd_ptr,
  input  logic [AW-1:0]      ld_addr,
  output logic [SB_BEW-1:0]  ld_fwd_mask,
  output logic [SB_DW-1:0]   ld_fwd_data
);

  logic [SB_AW-1:2] ld_word;
  logic [PW-1:0]    idx;

  assign ld_word = (SB_AW-2)'(ld_addr[AW-1:2]);

  always_comb begin
    ld_fwd_mask = '0;
    ld_fwd_data = '0;
    idx         = '0;
    for (int k = 0; k < DEPTH; k++) begin
      // Pointers are power-of-two wide, so the add wraps modulo DEPTH.
      idx = rd_ptr + PW'(k);
      if (valid[idx] && (entries[idx].addr == ld_word)) begin
        for (int i = 0; i < SB_BEW; i++) begin
          if (entries[idx].be[i]) begin
            ld_fwd_mask[i]        = 1'b1;
            ld_fwd_data[8*i +: 8] = entries[idx].data[8*i +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// FIFO of pending stores between the pipeline and data memory, with byte-wise
// forwarding to loads and strictly in-order drain.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [AW-1:0]            st_addr,
  input  logic [DW-1:0]            st_data,
  input  logic [DW/8-1:0]          st_be,
  input  logic [31:0]              st_pc,
  input  logic [AW-1:0]            ld_addr,
  output logic [DW/8-1:0]          ld_fwd_mask,
  output logic [DW-1:0]            ld_fwd_data,
  output logic                     dm_we,
  input  logic                     dm_ready,
  output logic [AW-1:0]            dm_addr,
  output logic [DW-1:0]            dm_wdata,
  output logic [DW/8-1:0]          dm_be,
  output logic [31:0]              dm_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t        entries [DEPTH];
  sb_entry_t        head;
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q;
  logic             enq;
  logic             deq;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign st_ready = !full;

  // A zero-enable store completes its handshake but occupies no slot.
  assign enq = st_valid && st_ready && (|st_be);
  assign deq = dm_we && dm_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      valid   <= '0;
    end else begin
      if (enq) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (deq) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      count_q <= count_q + CW'(enq) - CW'(deq);
    end
  end

  // Payload needs no reset; the valid bits and output gating hide stale slots.
  always_ff @(posedge clk) begin
    if (enq) begin
      entries[wr_ptr] <= '{addr: (SB_AW-2)'(st_addr[AW-1:2]),
                           data: SB_DW'(st_data),
                           be:   SB_BEW'(st_be),
                           pc:   st_pc};
    end
  end

  assign head  = entries[rd_ptr];
  assign dm_we = !empty;

  always_comb begin
    dm_addr  = '0;
    dm_wdata = '0;
    dm_be    = '0;
    dm_pc    = '0;
    if (dm_we) begin
      dm_addr  = AW'({head.addr, 2'b00});
      dm_wdata = DW'(head.data);
      dm_be    = (DW/8)'(head.be);
      dm_pc    = head.pc;
    end
  end

  logic [SB_BEW-1:0] fwd_mask;
  logic [SB_DW-1:0]  fwd_data;

  sb_fwd_merge #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fwd_merge (
    .entries     (entries),
    .valid       (valid),
    .rd_ptr      (rd_ptr),
    .ld_addr     (ld_addr),
    .ld_fwd_mask (fwd_mask),
    .ld_fwd_data (fwd_data)
  );

  assign ld_fwd_mask = (DW/8)'(fwd_mask);
  assign ld_fwd_data = DW'(fwd_data);

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer: reset, drain, back-pressure,
// forwarding merge, mid-drain reset and zero-enable stores.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic [31:0] st_pc;
  logic [31:0] ld_addr;
  logic [3:0]  ld_fwd_mask;
  logic [31:0] ld_fwd_data;
  logic        dm_we;
  logic        dm_ready;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_pc;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  int total = 0;
  int bad   = 0;

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_be       (st_be),
    .st_pc       (st_pc),
    .ld_addr     (ld_addr),
    .ld_fwd_mask (ld_fwd_mask),
    .ld_fwd_data (ld_fwd_data),
    .dm_we       (dm_we),
    .dm_ready    (dm_ready),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_be       (dm_be),
    .dm_pc       (dm_pc),
    .count       (count),
    .empty       (empty),
    .full        (full)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] be, input logic [31:0] pc);
    st_valid = v;
    st_addr  = a;
    st_data  = d;
    st_be    = be;
    st_pc    = pc;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    dm_ready = 1'b0;
    ld_addr  = 32'h10;
    tick();
    tick();
    total++; if (st_ready !== 1'b1) begin bad++; $display("FAIL reset_st_ready got=%b exp=1", st_ready); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (dm_we !== 1'b0) begin bad++; $display("FAIL reset_dm_we got=%b exp=0", dm_we); end
    total++; if ({dm_addr, dm_wdata, dm_be, dm_pc} !== 100'h0) begin bad++; $display("FAIL reset_dm_bus got=%h/%h/%h/%h exp=0", dm_addr, dm_wdata, dm_be, dm_pc); end
    total++; if ({ld_fwd_mask, ld_fwd_data} !== 36'h0) begin bad++; $display("FAIL reset_fwd got=%h/%h exp=0", ld_fwd_mask, ld_fwd_data); end
    reset = 1'b0;
    #1;
    total++; if (st_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b exp=1", st_ready); end
  endtask

  task automatic test_basic;
    dm_ready = 1'b0;
    applyStimulus(1'b1, 32'h10, 32'h11223344, 4'hF, 32'h3000);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    ld_addr = 32'h10;
    #1;
    total++; if (dm_we !== 1'b1) begin bad++; $display("FAIL basic_dm_we got=%b exp=1", dm_we); end
    total++; if (dm_addr !== 32'h10) begin bad++; $display("FAIL basic_dm_addr got=%h exp=00000010", dm_addr); end
    total++; if (dm_wdata !== 32'h11223344) begin bad++; $display("FAIL basic_dm_wdata got=%h exp=11223344", dm_wdata); end
    total++; if (dm_pc !== 32'h3000) begin bad++; $display("FAIL basic_dm_pc got=%h exp=00003000", dm_pc); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL basic_count got=%0d exp=1", count); end
    total++; if (ld_fwd_mask !== 4'hF || ld_fwd_data !== 32'h11223344) begin bad++; $display("FAIL basic_fwd got=%h/%h exp=f/11223344", ld_fwd_mask, ld_fwd_data); end
    tick();
    total++; if (dm_addr !== 32'h10 || dm_be !== 4'hF || count !== 3'd1) begin bad++; $display("FAIL basic_hold got=%h/%h/%0d exp=00000010/f/1", dm_addr, dm_be, count); end
    dm_ready = 1'b1;
    tick();
    total++; if (empty !== 1'b1 || dm_we !== 1'b0) begin bad++; $display("FAIL basic_drained got=%b/%b exp=1/0", empty, dm_we); end
    dm_ready = 1'b0;
  endtask

  task automatic test_fill;
    logic [31:0] exp_d [4];
    logic [31:0] exp_a [4];
    logic [31:0] exp_p [4];
    exp_d = '{32'hD1, 32'hD2, 32'hD3, 32'hE4};
    exp_a = '{32'h44, 32'h48, 32'h4C, 32'h50};
    exp_p = '{32'h101, 32'h102, 32'h103, 32'h104};
    dm_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 32'h40 + 32'(4*k), 32'hD0 + 32'(k), 4'hF, 32'h100 + 32'(k));
      tick();
    end
    applyStimulus(1'b1, 32'h60, 32'hBAD, 4'hF, 32'h1FF);
    #1;
    total++; if (full !== 1'b1 || st_ready !== 1'b0 || count !== 3'd4) begin bad++; $display("FAIL fill_full got=%b/%b/%0d exp=1/0/4", full, st_ready, count); end
    tick();
    total++; if (count !== 3'd4 || dm_wdata !== 32'hD0) begin bad++; $display("FAIL fill_5th_ignored got=%0d/%h exp=4/000000d0", count, dm_wdata); end
    applyStimulus(1'b1, 32'h50, 32'hE4, 4'hF, 32'h104);
    dm_ready = 1'b1;
    #1;
    total++; if (st_ready !== 1'b0) begin bad++; $display("FAIL fill_no_passthrough got=%b exp=0", st_ready); end
    tick();
    total++; if (count !== 3'd3 || dm_wdata !== 32'hD1) begin bad++; $display("FAIL fill_drain_one got=%0d/%h exp=3/000000d1", count, dm_wdata); end
    dm_ready = 1'b0;
    tick();
    total++; if (count !== 3'd4 || full !== 1'b1) begin bad++; $display("FAIL fill_refill got=%0d/%b exp=4/1", count, full); end
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    dm_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      total++; if (dm_wdata !== exp_d[j] || dm_addr !== exp_a[j] || dm_pc !== exp_p[j]) begin bad++; $display("FAIL fill_order_%0d got=%h/%h/%h exp=%h/%h/%h", j, dm_wdata, dm_addr, dm_pc, exp_d[j], exp_a[j], exp_p[j]); end
      tick();
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL fill_end_empty got=%b exp=1", empty); end
    dm_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    dm_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 32'h80 + 32'(4*k), 32'hC0 + 32'(k), 4'hF, 32'h400 + 32'(k));
      tick();
      total++; if (count !== 3'd1 || dm_wdata !== 32'hC0 + 32'(k)) begin bad++; $display("FAIL b2b_%0d got=%0d/%h exp=1/%h", k, count, dm_wdata, 32'hC0 + 32'(k)); end
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    tick();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%b exp=1", empty); end
    dm_ready = 1'b0;
  endtask

  task automatic test_forward;
    dm_ready = 1'b0;
    ld_addr  = 32'h20;
    applyStimulus(1'b1, 32'h20, 32'hAABBCCDD, 4'hF, 32'h200);
    #1;
    total++; if (ld_fwd_mask !== 4'h0) begin bad++; $display("FAIL fwd_same_cycle got=%h exp=0", ld_fwd_mask); end
    tick();
    applyStimulus(1'b1, 32'h22, 32'h0000EE00, 4'b0010, 32'h204);
    #1;
    total++; if (ld_fwd_mask !== 4'hF || ld_fwd_data !== 32'hAABBCCDD) begin bad++; $display("FAIL fwd_first_only got=%h/%h exp=f/aabbccdd", ld_fwd_mask, ld_fwd_data); end
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    #1;
    total++; if (ld_fwd_mask !== 4'hF || ld_fwd_data !== 32'hAABBEEDD) begin bad++; $display("FAIL fwd_merge got=%h/%h exp=f/aabbeedd", ld_fwd_mask, ld_fwd_data); end
    ld_addr = 32'h23;
    #1;
    total++; if (ld_fwd_mask !== 4'hF || ld_fwd_data !== 32'hAABBEEDD) begin bad++; $display("FAIL fwd_unaligned got=%h/%h exp=f/aabbeedd", ld_fwd_mask, ld_fwd_data); end
    ld_addr = 32'h24;
    #1;
    total++; if (ld_fwd_mask !== 4'h0 || ld_fwd_data !== 32'h0) begin bad++; $display("FAIL fwd_miss got=%h/%h exp=0/0", ld_fwd_mask, ld_fwd_data); end
    dm_ready = 1'b1;
    tick();
    ld_addr = 32'h20;
    #1;
    total++; if (dm_addr !== 32'h20 || dm_be !== 4'b0010 || dm_pc !== 32'h204) begin bad++; $display("FAIL fwd_second_head got=%h/%h/%h exp=00000020/2/00000204", dm_addr, dm_be, dm_pc); end
    total++; if (ld_fwd_mask !== 4'b0010 || ld_fwd_data !== 32'h0000EE00) begin bad++; $display("FAIL fwd_after_drain got=%h/%h exp=2/0000ee00", ld_fwd_mask, ld_fwd_data); end
    tick();
    total++; if (empty !== 1'b1 || ld_fwd_mask !== 4'h0) begin bad++; $display("FAIL fwd_end got=%b/%h exp=1/0", empty, ld_fwd_mask); end
    dm_ready = 1'b0;
  endtask

  task automatic test_zero_be;
    dm_ready = 1'b0;
    ld_addr  = 32'h30;
    applyStimulus(1'b1, 32'h30, 32'h11111111, 4'hF, 32'h300);
    tick();
    applyStimulus(1'b1, 32'h30, 32'h22222222, 4'h0, 32'h304);
    #1;
    total++; if (st_ready !== 1'b1) begin bad++; $display("FAIL zbe_ready got=%b exp=1", st_ready); end
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    #1;
    total++; if (count !== 3'd1 || dm_pc !== 32'h300) begin bad++; $display("FAIL zbe_count got=%0d/%h exp=1/00000300", count, dm_pc); end
    total++; if (ld_fwd_mask !== 4'hF || ld_fwd_data !== 32'h11111111) begin bad++; $display("FAIL zbe_fwd got=%h/%h exp=f/11111111", ld_fwd_mask, ld_fwd_data); end
    dm_ready = 1'b1;
    tick();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL zbe_empty got=%b exp=1", empty); end
    dm_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    int writes;
    dm_ready = 1'b0;
    ld_addr  = 32'h90;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 32'h90 + 32'(4*k), 32'hF0 + 32'(k), 4'hF, 32'h500 + 32'(k));
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    #1;
    total++; if (count !== 3'd3 || dm_we !== 1'b1) begin bad++; $display("FAIL rmid_pending got=%0d/%b exp=3/1", count, dm_we); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (dm_we !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin bad++; $display("FAIL rmid_async got=%b/%0d/%b exp=0/0/1", dm_we, count, empty); end
    total++; if (ld_fwd_mask !== 4'h0 || dm_addr !== 32'h0) begin bad++; $display("FAIL rmid_outputs got=%h/%h exp=0/0", ld_fwd_mask, dm_addr); end
    dm_ready = 1'b1;
    tick();
    reset = 1'b0;
    writes = 0;
    for (int j = 0; j < 3; j++) begin
      if (dm_we === 1'b1) writes++;
      tick();
    end
    total++; if (writes !== 0) begin bad++; $display("FAIL rmid_no_writes got=%0d exp=0", writes); end
    dm_ready = 1'b0;
    applyStimulus(1'b1, 32'hA0, 32'h5A5A5A5A, 4'hF, 32'h600);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    #1;
    total++; if (count !== 3'd1 || dm_wdata !== 32'h5A5A5A5A || dm_addr !== 32'hA0) begin bad++; $display("FAIL rmid_restart got=%0d/%h/%h exp=1/5a5a5a5a/000000a0", count, dm_wdata, dm_addr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_back_to_back();
    test_forward();
    test_zero_be();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
